imm_encode: RTL and testbench

//  Inverse of the immediate sign-extend decoder: packs a 32-bit immediate into a 32-bit

---
 rtl/imm_encode_if.sv | 27 ++
 rtl/imm_encode.sv | 148 ++++++++++++++
 tb/tb_imm_encode.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encode_if.sv
// imm_encode_if: request/response bundle for the immediate encoder.
// The slave modport is the encoder's view; the master modport is the
// producer/consumer side (instruction generator or bench).
interface imm_encode_if #(
    parameter int CNT_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_type;
    logic [31:0]      i_tmpl;
    logic [31:0]      i_imm;
    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_instr;
    logic             o_err;
    logic [CNT_W-1:0] o_err_cnt;

    modport slave (
        input  i_valid, i_type, i_tmpl, i_imm, i_ready,
        output o_ready, o_valid, o_instr, o_err, o_err_cnt
    );

    modport master (
        output i_valid, i_type, i_tmpl, i_imm, i_ready,
        input  o_ready, o_valid, o_instr, o_err, o_err_cnt
    );
endinterface

// File: rtl/imm_encode.sv
// imm_encode: packs a 32-bit immediate into an instruction template by
// format (R/I/S/B/U/J), the inverse of the decoder's sign-extend logic.
// Two-stage valid/ready pipeline: stage 1 captures the request together
// with its encoding, stage 2 is the output register.
// Optional build macro IMM_RANGE_CHECK_EN: flag immediates that the chosen
// format cannot represent. The instruction word is truncated silently
// either way; only the error sideband differs.
module imm_encode #(
    parameter int CNT_W = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    imm_encode_if.slave   bus
);
    localparam logic [2:0] TY_NO  = 3'd0;
    localparam logic [2:0] TY_RT  = 3'd1;
    localparam logic [2:0] TY_IT  = 3'd2;
    localparam logic [2:0] TY_ST  = 3'd3;
    localparam logic [2:0] TY_BT  = 3'd4;
    localparam logic [2:0] TY_UT  = 3'd5;
    localparam logic [2:0] TY_JT  = 3'd6;
    localparam logic [2:0] TY_ILL = 3'd7;

    // Overwrite only the immediate fields of the template; all other bits pass.
    function automatic logic [31:0] encode_imm(input logic [2:0] ty,
                                               input logic [31:0] tmpl,
                                               input logic [31:0] imm);
        logic [31:0] w;
        w = tmpl;
        case (ty)
            TY_RT: w[31:25] = imm[11:5];
            TY_IT: w[31:20] = imm[11:0];
            TY_ST: begin
                w[31:25] = imm[11:5];
                w[11:7]  = imm[4:0];
            end
            TY_BT: begin
                w[31]    = imm[12];
                w[30:25] = imm[10:5];
                w[11:8]  = imm[4:1];
                w[7]     = imm[11];
            end
            TY_UT: w[31:12] = imm[31:12];
            TY_JT: begin
                w[31]    = imm[20];
                w[30:21] = imm[10:1];
                w[20]    = imm[11];
                w[19:12] = imm[19:12];
            end
            default: w = tmpl;
        endcase
        return w;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // Not representable: bits above the sign position disagree with the sign,
    // or low bits the format cannot hold are set.
    function automatic logic range_err(input logic [2:0] ty, input logic [31:0] imm);
        logic bad;
        bad = 1'b0;
        case (ty)
            TY_RT:        bad = (imm[31:11] != {21{imm[31]}}) | (|imm[4:0]);
            TY_IT, TY_ST: bad = (imm[31:11] != {21{imm[31]}});
            TY_BT:        bad = (imm[31:12] != {20{imm[31]}}) | imm[0];
            TY_JT:        bad = (imm[31:20] != {12{imm[31]}}) | imm[0];
            TY_UT:        bad = |imm[11:0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction
`else
    function automatic logic range_err(input logic [2:0] ty, input logic [31:0] imm);
        logic unused;
        unused = ^{ty, imm};
        return 1'b0;
    endfunction
`endif

    logic             vld_p1;
    logic [31:0]      instr_p1;
    logic             err_p1;
    logic             vld_p2;
    logic [31:0]      instr_p2;
    logic             err_p2;
    logic [CNT_W-1:0] err_cnt;

    logic             s2_adv;
    logic             s2_load;
    logic             in_ready;
    logic             accept;
    logic [31:0]      enc_instr;
    logic             enc_err;

    // Handshake: stage 2 frees when empty or draining; stage 1 takes a new
    // item whenever it is empty or its occupant moves into stage 2 this cycle.
    always_comb begin
        s2_adv    = vld_p2 & bus.i_ready;
        s2_load   = !vld_p2 | s2_adv;
        in_ready  = !vld_p1 | s2_load;
        accept    = bus.i_valid & in_ready;
        enc_instr = encode_imm(bus.i_type, bus.i_tmpl, bus.i_imm);
        enc_err   = (bus.i_type == TY_ILL) | range_err(bus.i_type, bus.i_imm);
    end

    // Stage 1: capture the request and its encoding.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= bus.i_valid;
        end
        if (accept) begin
            instr_p1 <= enc_instr;
            err_p1   <= enc_err;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p2   <= 1'b0;
            instr_p2 <= '0;
            err_p2   <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                instr_p2 <= instr_p1;
                err_p2   <= err_p1;
            end
        end
    end

    // Count erroneous words as they are handed off; stick at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt <= '0;
        end else if (s2_adv && err_p2 && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.o_ready   = in_ready;
    assign bus.o_valid   = vld_p2;
    assign bus.o_instr   = instr_p2;
    assign bus.o_err     = err_p2;
    assign bus.o_err_cnt = err_cnt;

endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: directed bench for imm_encode. A queue-based reference
// model predicts every output word from the format rules using masks,
// shifts and signed range arithmetic; literal vectors pin the model.
module tb_imm_encode;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [2:0]  ty;
        logic [31:0] tmpl;
        logic [31:0] imm;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   mcnt = 0;

    always #5 clk = ~clk;

    imm_encode_if #(.CNT_W(CNT_W)) bus ();

    imm_encode #(.CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Reference encoder: clear the format's immediate field mask, OR in
    // the shifted immediate slices.
    function automatic logic [31:0] m_encode(input int ty, input logic [31:0] tmpl,
                                             input logic [31:0] imm);
        case (ty)
            1: return (tmpl & ~32'hFE000000) | (((imm >> 5) & 32'h7F) << 25);
            2: return (tmpl & ~32'hFFF00000) | ((imm & 32'hFFF) << 20);
            3: return (tmpl & ~32'hFE000F80) | (((imm >> 5) & 32'h7F) << 25)
                      | ((imm & 32'h1F) << 7);
            4: return (tmpl & ~32'hFE000F80) | (((imm >> 12) & 32'h1) << 31)
                      | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                      | (((imm >> 11) & 32'h1) << 7);
            5: return (tmpl & 32'h00000FFF) | (imm & 32'hFFFFF000);
            6: return (tmpl & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31)
                      | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                      | (((imm >> 12) & 32'hFF) << 12);
            default: return tmpl;
        endcase
    endfunction

    // Representability as signed byte-offset ranges and alignment.
    function automatic bit m_range_bad(input int ty, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (ty)
            1: return (s < -2048) || (s > 2047) || ((s % 32) != 0);
            2, 3: return (s < -2048) || (s > 2047);
            4: return (s < -4096) || (s > 4095) || ((s % 2) != 0);
            5: return (imm & 32'hFFF) != 0;
            6: return (s < -(64'sd1 << 20)) || (s > ((64'sd1 << 20) - 1)) || ((s % 2) != 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_err(input int ty, input logic [31:0] imm);
        return (ty == 7) || (RC && m_range_bad(ty, imm));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: check the presented word against the oldest expectation
    // on every cycle, retire it on transfer, and track the error count.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            chk("err_cnt", 64'(bus.o_err_cnt), 64'(mcnt));
            if (bus.o_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(bus.o_valid), 64'd0);
                end else begin
                    chk("o_instr", 64'(bus.o_instr), 64'(q[0].instr));
                    chk("o_err", 64'(bus.o_err), 64'(q[0].err));
                    if (bus.i_ready) begin
                        if (q[0].err && mcnt != CNT_MAX) mcnt++;
                        void'(q.pop_front());
                    end
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                q.push_back('{instr: m_encode(int'(bus.i_type), bus.i_tmpl, bus.i_imm),
                              err:   m_err(int'(bus.i_type), bus.i_imm)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one item and hold it until accepted (bounded).
    task automatic send(input logic [2:0] ty, input logic [31:0] tmpl,
                        input logic [31:0] imm, output int waits);
        bus.i_valid = 1'b1;
        bus.i_type  = ty;
        bus.i_tmpl  = tmpl;
        bus.i_imm   = imm;
        waits = 0;
        #1;
        while (!bus.o_ready && waits < 100) begin
            tick();
            waits++;
        end
        if (!bus.o_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: o_ready stayed 0 for %0d cycles, required 1", waits);
        end else begin
            tick();
        end
        bus.i_valid = 1'b0;
    endtask

    // Single item through an empty pipe, with literal expectations.
    task automatic lit(input string name, input logic [2:0] ty, input logic [31:0] tmpl,
                       input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
        int w;
        send(ty, tmpl, imm, w);
        chk({name, "_valid_early"}, 64'(bus.o_valid), 64'd0);
        tick();
        chk({name, "_valid"}, 64'(bus.o_valid), 64'd1);
        chk({name, "_instr"}, 64'(bus.o_instr), 64'(exp_instr));
        chk({name, "_err"}, 64'(bus.o_err), 64'(exp_err));
        tick();
    endtask

    vec_t        tbl[16];
    vec_t        strm[4];
    logic [7:0]  rpat;
    logic [31:0] sexp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int idx;
        int cyc;
        bit acc;

        bus.i_valid = 1'b0;
        bus.i_type  = 3'd0;
        bus.i_tmpl  = 32'h0;
        bus.i_imm   = 32'h0;
        bus.i_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_o_instr", 64'(bus.o_instr), 64'd0);
        chk("rst_o_err", 64'(bus.o_err), 64'd0);
        chk("rst_err_cnt", 64'(bus.o_err_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // Pin the reference model with hand-derived words
        chk("model_it", 64'(m_encode(2, 32'h13, 32'hFFFFFFFF)), 64'h00000000FFF00013);
        chk("model_bt", 64'(m_encode(4, 32'h63, 32'hFFFFFFFC)), 64'h00000000FE000EE3);
        chk("model_jt", 64'(m_encode(6, 32'h6F, 32'h8)), 64'h000000000080006F);
        chk("model_ut", 64'(m_encode(5, 32'h37, 32'h12345000)), 64'h0000000012345037);
        chk("model_it800", 64'(m_encode(2, 32'h13, 32'h800)), 64'h0000000080000013);
        chk("model_rng_it800", 64'(m_range_bad(2, 32'h800)), 64'd1);
        chk("model_rng_bt_m4", 64'(m_range_bad(4, 32'hFFFFFFFC)), 64'd0);

        // Literal vectors, two-cycle latency from an empty pipe
        lit("it_m1", 3'd2, 32'h00000013, 32'hFFFFFFFF, 32'hFFF00013, 1'b0);
        lit("bt_m4", 3'd4, 32'h00000063, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        lit("jt_8", 3'd6, 32'h0000006F, 32'h00000008, 32'h0080006F, 1'b0);
        lit("ut", 3'd5, 32'h00000037, 32'h12345000, 32'h12345037, 1'b0);
        lit("it_800", 3'd2, 32'h00000013, 32'h00000800, 32'h80000013, RC);
        chk("it_800_cnt", 64'(bus.o_err_cnt), 64'(RC));
        lit("illegal", 3'd7, 32'h12345678, 32'h0000ABCD, 32'h12345678, 1'b1);
        lit("no_type", 3'd0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0);

        // Back-to-back stream: one accept and one output per cycle
        strm[0] = '{ty: 3'd1, tmpl: 32'h00000033, imm: 32'h000007E0};
        strm[1] = '{ty: 3'd3, tmpl: 32'h00002023, imm: 32'h000007FF};
        strm[2] = '{ty: 3'd4, tmpl: 32'h00000063, imm: 32'h00000FFE};
        strm[3] = '{ty: 3'd6, tmpl: 32'h000000EF, imm: 32'hFFF00000};
        for (int k = 0; k < 4; k++) begin
            send(strm[k].ty, strm[k].tmpl, strm[k].imm, w);
            if (k >= 1) begin
                chk("stream_no_stall", 64'(w), 64'd0);
                sexp = m_encode(int'(strm[k-1].ty), strm[k-1].tmpl, strm[k-1].imm);
                chk("stream_valid", 64'(bus.o_valid), 64'd1);
                chk("stream_instr", 64'(bus.o_instr), 64'(sexp));
            end
        end
        tick();
        sexp = m_encode(int'(strm[3].ty), strm[3].tmpl, strm[3].imm);
        chk("stream_last_valid", 64'(bus.o_valid), 64'd1);
        chk("stream_last_instr", 64'(bus.o_instr), 64'(sexp));
        repeat (3) tick();

        // Backpressure: two items fill the pipe, third waits, output held
        bus.i_ready = 1'b0;
        send(3'd5, 32'h00000037, 32'h12345000, w);
        send(3'd2, 32'h00000013, 32'h00000123, w);
        bus.i_valid = 1'b1;
        bus.i_type  = 3'd1;
        bus.i_tmpl  = 32'h00000033;
        bus.i_imm   = 32'h00000040;
        #1;
        chk("bp_ready_low", 64'(bus.o_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ready_low", 64'(bus.o_ready), 64'd0);
            chk("bp_hold_valid", 64'(bus.o_valid), 64'd1);
            chk("bp_hold_instr", 64'(bus.o_instr), 64'h12345037);
        end
        bus.i_ready = 1'b1;
        send(3'd1, 32'h00000033, 32'h00000040, w);
        repeat (4) tick();
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Directed table under a patterned consumer
        tbl[0]  = '{ty: 3'd1, tmpl: 32'h40000033, imm: 32'h00000021};
        tbl[1]  = '{ty: 3'd2, tmpl: 32'h00000013, imm: 32'hFFFFF800};
        tbl[2]  = '{ty: 3'd2, tmpl: 32'h00000093, imm: 32'h00000FFF};
        tbl[3]  = '{ty: 3'd3, tmpl: 32'hFFFFFFFF, imm: 32'hFFFFF800};
        tbl[4]  = '{ty: 3'd3, tmpl: 32'h00002023, imm: 32'h00000800};
        tbl[5]  = '{ty: 3'd4, tmpl: 32'h00001063, imm: 32'h00001000};
        tbl[6]  = '{ty: 3'd4, tmpl: 32'h00000063, imm: 32'h00000003};
        tbl[7]  = '{ty: 3'd4, tmpl: 32'h00000063, imm: 32'hFFFFF000};
        tbl[8]  = '{ty: 3'd5, tmpl: 32'h000000B7, imm: 32'hFFFFF000};
        tbl[9]  = '{ty: 3'd5, tmpl: 32'h000000B7, imm: 32'h00000001};
        tbl[10] = '{ty: 3'd6, tmpl: 32'h000000EF, imm: 32'h000FFFFE};
        tbl[11] = '{ty: 3'd6, tmpl: 32'h000000EF, imm: 32'h00100000};
        tbl[12] = '{ty: 3'd6, tmpl: 32'h0000006F, imm: 32'h00000005};
        tbl[13] = '{ty: 3'd7, tmpl: 32'hCAFEF00D, imm: 32'h00000000};
        tbl[14] = '{ty: 3'd0, tmpl: 32'h01234567, imm: 32'h89ABCDEF};
        tbl[15] = '{ty: 3'd1, tmpl: 32'h00000033, imm: 32'hFFFFF800};
        rpat = 8'b1101_0110;
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 300) begin
            bus.i_ready = rpat[cyc % 8];
            bus.i_valid = 1'b1;
            bus.i_type  = tbl[idx].ty;
            bus.i_tmpl  = tbl[idx].tmpl;
            bus.i_imm   = tbl[idx].imm;
            #1;
            acc = bus.o_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        chk("table_all_accepted", 64'(idx), 64'd16);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        repeat (4) tick();
        chk("table_drained", 64'(q.size()), 64'd0);

        // Saturation: more errors than the counter can hold
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            send(3'd7, 32'h00000000, 32'(k), w);
        end
        repeat (4) tick();
        chk("cnt_saturated", 64'(bus.o_err_cnt), 64'(CNT_MAX));

        // Reset with two items in flight
        bus.i_ready = 1'b0;
        send(3'd2, 32'h00000013, 32'h00000111, w);
        send(3'd2, 32'h00000013, 32'h00000222, w);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(bus.o_valid), 64'd0);
        chk("mid_rst_cnt", 64'(bus.o_err_cnt), 64'd0);
        chk("mid_rst_ready", 64'(bus.o_ready), 64'd1);
        chk("mid_rst_instr", 64'(bus.o_instr), 64'd0);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        repeat (2) tick();
        chk("post_rst_idle", 64'(bus.o_valid), 64'd0);
        lit("post_rst", 3'd2, 32'h00000013, 32'h00000005, 32'h00500013, 1'b0);
        repeat (2) tick();
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
